vga_frame_driver: RTL and testbench

Display back end of the Genius video path. Buffers the 24-bit pixel stream produced by the pixel loader in a small FIFO and generates VGA timing (HSYNC/VSYNC, active-video window) at a pixel rate of CLK/CLK_DIV. It drives the loader's interface-enable through PIX_REQ and emits blanked, registered RGB toward the DAC/pins.

---
 rtl/vga_frame_driver.sv | 119 +++++++++++
 tb/tb_vga_frame_driver.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_frame_driver.sv
// rtl/vga_frame_driver.sv - VGA timing generator with pixel FIFO and blanked, registered RGB
module vga_frame_driver #(
  parameter int          H_ACTIVE   = 640,
  parameter int          H_FP       = 16,
  parameter int          H_SYNC     = 96,
  parameter int          H_BP       = 48,
  parameter int          V_ACTIVE   = 480,
  parameter int          V_FP       = 10,
  parameter int          V_SYNC     = 2,
  parameter int          V_BP       = 33,
  parameter int          CLK_DIV    = 4,
  parameter int          FIFO_DEPTH = 8,
  parameter bit          SYNC_POL   = 1'b0,
  parameter logic [23:0] UF_COLOR   = 24'hFF00FF
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [23:0] PIX_IN,
  input  logic        PIX_VALID,
  output logic        PIX_REQ,
  output logic        HSYNC,
  output logic        VSYNC,
  output logic [23:0] VGA_RGB,
  output logic        DE,
  output logic        FRAME_START,
  output logic        UNDERFLOW,
  output logic        OVERFLOW
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] REQ_MAX  = CW'(FIFO_DEPTH - 2);

  logic [DW-1:0] div;
  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic [23:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;

  logic tick, active, empty, full, push, pop;

  assign tick   = (div == DIV_LAST);
  assign active = (h < H_ACT) && (v < V_ACT);
  assign empty  = (count == '0);
  assign full   = (count == CNT_FULL);
  assign push   = PIX_VALID && !full;
  assign pop    = tick && active && !empty;

  assign PIX_REQ = !RESET && (count <= REQ_MAX);

  // Storage has no reset; validity is tracked entirely by the pointers and count.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= PIX_IN;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      div         <= '0;
      h           <= '0;
      v           <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      VGA_RGB     <= '0;
      DE          <= 1'b0;
      HSYNC       <= ~SYNC_POL;
      VSYNC       <= ~SYNC_POL;
      FRAME_START <= 1'b0;
      UNDERFLOW   <= 1'b0;
      OVERFLOW    <= 1'b0;
    end else begin
      div <= tick ? '0 : div + 1'b1;

      // Outputs reflect the pre-increment position so pixel (0,0) leads the frame.
      if (tick) begin
        if (h == H_LAST) begin
          h <= '0;
          v <= (v == V_LAST) ? '0 : v + 1'b1;
        end else begin
          h <= h + 1'b1;
        end
        DE    <= active;
        HSYNC <= (h >= HS_START && h < HS_END) ? SYNC_POL : ~SYNC_POL;
        VSYNC <= (v >= VS_START && v < VS_END) ? SYNC_POL : ~SYNC_POL;
        if (!active)    VGA_RGB <= '0;
        else if (empty) VGA_RGB <= UF_COLOR;
        else            VGA_RGB <= mem[rd_ptr];
        if (active && empty) UNDERFLOW <= 1'b1;
      end

      FRAME_START <= tick && (h == '0) && (v == '0);

      if (PIX_VALID && full) OVERFLOW <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_vga_frame_driver.sv
// tb/tb_vga_frame_driver.sv - randomized self-checking bench for vga_frame_driver (small config)
module tb_vga_frame_driver;
  localparam int HA = 4, HF = 1, HS = 2, HB = 1;
  localparam int VA = 3, VF = 1, VS = 1, VB = 1;
  localparam int DIV = 2, DEPTH = 4;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam logic [23:0] UF = 24'hFF00FF;
  localparam logic [30:0] RESET_VEC = {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 24'h0};

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [23:0] PIX_IN = '0;
  logic        PIX_VALID = 1'b0;
  logic        PIX_REQ, HSYNC, VSYNC, DE, FRAME_START, UNDERFLOW, OVERFLOW;
  logic [23:0] VGA_RGB;

  vga_frame_driver #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .CLK_DIV(DIV), .FIFO_DEPTH(DEPTH), .SYNC_POL(1'b0), .UF_COLOR(UF)
  ) dut (
    .CLK(CLK), .RESET(RESET), .PIX_IN(PIX_IN), .PIX_VALID(PIX_VALID),
    .PIX_REQ(PIX_REQ), .HSYNC(HSYNC), .VSYNC(VSYNC), .VGA_RGB(VGA_RGB),
    .DE(DE), .FRAME_START(FRAME_START), .UNDERFLOW(UNDERFLOW), .OVERFLOW(OVERFLOW)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass = 0;

  // Reference model: t counts cycles since reset release; position derives from t by arithmetic.
  int          t;
  logic [23:0] q[$];
  logic [23:0] e_rgb;
  logic        e_de, e_hs, e_vs, e_fs, e_uf, e_of;

  function automatic logic [30:0] obs_vec();
    return {DE, HSYNC, VSYNC, FRAME_START, UNDERFLOW, OVERFLOW, PIX_REQ, VGA_RGB};
  endfunction

  function automatic logic [30:0] exp_vec();
    logic req;
    req = !RESET && (q.size() <= DEPTH - 2);
    return {e_de, e_hs, e_vs, e_fs, e_uf, e_of, req, e_rgb};
  endfunction

  task automatic model_clear();
    q.delete();
    t = 0;
    e_rgb = '0; e_de = 0; e_hs = 1; e_vs = 1; e_fs = 0; e_uf = 0; e_of = 0;
  endtask

  task automatic step(input logic valid, input logic [23:0] pix);
    int start_size, k, n, h, v;
    logic tick, active;
    start_size = q.size();
    tick   = (t % DIV) == DIV - 1;
    k      = t / DIV;
    n      = k % (HT * VT);
    h      = n % HT;
    v      = n / HT;
    active = (h < HA) && (v < VA);
    PIX_VALID = valid;
    PIX_IN    = pix;
    e_fs = tick && (n == 0);
    if (tick) begin
      e_de = active;
      e_hs = !(h >= HA + HF && h < HA + HF + HS);
      e_vs = !(v >= VA + VF && v < VA + VF + VS);
      if (!active) e_rgb = '0;
      else if (start_size > 0) e_rgb = q.pop_front();
      else begin
        e_rgb = UF;
        e_uf  = 1;
      end
    end
    if (valid) begin
      if (start_size == DEPTH) e_of = 1;
      else q.push_back(pix);
    end
    t++;
    @(posedge CLK); #1;
    PIX_VALID = 1'b0;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    PIX_VALID = 1'b0;
    @(posedge CLK); #1;
    RESET = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    @(posedge CLK); #1;
    n_checks++;
    if (obs_vec() !== RESET_VEC) $display("FAIL reset_values got %h want %h", obs_vec(), RESET_VEC);
    else n_pass++;
    RESET = 1'b0;
    model_clear();
    #1;
    n_checks++;
    if (PIX_REQ !== 1'b1) $display("FAIL reset_pix_req got %b want 1", PIX_REQ);
    else n_pass++;
  endtask

  task automatic test_free_run();
    int fs_last, n_fs, hs_run, vs_run;
    logic hs_prev, vs_prev;
    do_reset();
    fs_last = -1; n_fs = 0; hs_run = 0; vs_run = 0; hs_prev = 1; vs_prev = 1;
    for (int i = 0; i < 2 * 96 + 6; i++) begin
      step(1'b0, 24'h0);
      n_checks++;
      if (obs_vec() !== exp_vec()) $display("FAIL free_run t=%0d got %h want %h", t, obs_vec(), exp_vec());
      else n_pass++;
      if (FRAME_START === 1'b1) begin
        if (fs_last >= 0) begin
          n_checks++;
          if (t - fs_last != 96) $display("FAIL frame_period got %0d want 96", t - fs_last);
          else n_pass++;
        end
        fs_last = t;
        n_fs++;
      end
      if (HSYNC === 1'b0) hs_run++;
      else if (hs_prev === 1'b0) begin
        n_checks++;
        if (hs_run != 4) $display("FAIL hsync_width got %0d want 4", hs_run);
        else n_pass++;
        hs_run = 0;
      end
      if (VSYNC === 1'b0) vs_run++;
      else if (vs_prev === 1'b0) begin
        n_checks++;
        if (vs_run != 16) $display("FAIL vsync_width got %0d want 16", vs_run);
        else n_pass++;
        vs_run = 0;
      end
      hs_prev = HSYNC;
      vs_prev = VSYNC;
    end
    n_checks++;
    if (n_fs != 3) $display("FAIL frame_start_count got %0d want 3", n_fs);
    else n_pass++;
  endtask

  task automatic test_stream();
    int next_pix;
    logic val;
    do_reset();
    next_pix = 1;
    for (int i = 0; i < 120; i++) begin
      val = (q.size() <= DEPTH - 2);
      step(val, 24'(next_pix));
      if (val) next_pix++;
      n_checks++;
      if (obs_vec() !== exp_vec()) $display("FAIL stream t=%0d got %h want %h", t, obs_vec(), exp_vec());
      else n_pass++;
      if (t >= 2 && t < 10 && (t % 2) == 0) begin
        n_checks++;
        if (VGA_RGB !== 24'((t - 2) / 2 + 1) || DE !== 1'b1)
          $display("FAIL stream_line0 t=%0d got rgb=%h de=%b want rgb=%h de=1", t, VGA_RGB, DE, 24'((t - 2) / 2 + 1));
        else n_pass++;
      end
    end
    n_checks++;
    if (UNDERFLOW !== 1'b0 || OVERFLOW !== 1'b0)
      $display("FAIL stream_flags got uf=%b of=%b want 0 0", UNDERFLOW, OVERFLOW);
    else n_pass++;
  endtask

  task automatic test_underflow();
    logic val;
    do_reset();
    step(1'b0, 24'h0);
    step(1'b0, 24'h0);
    n_checks++;
    if (VGA_RGB !== UF || DE !== 1'b1 || UNDERFLOW !== 1'b1)
      $display("FAIL underflow_first got rgb=%h de=%b uf=%b want ff00ff 1 1", VGA_RGB, DE, UNDERFLOW);
    else n_pass++;
    for (int i = 0; i < 60; i++) begin
      val = (q.size() <= DEPTH - 2);
      step(val, 24'($urandom));
      n_checks++;
      if (obs_vec() !== exp_vec()) $display("FAIL underflow_run t=%0d got %h want %h", t, obs_vec(), exp_vec());
      else n_pass++;
    end
    n_checks++;
    if (UNDERFLOW !== 1'b1) $display("FAIL underflow_sticky got %b want 1", UNDERFLOW);
    else n_pass++;
  endtask

  task automatic test_overflow();
    logic [23:0] pix[5];
    for (int j = 0; j < 5; j++) pix[j] = 24'($urandom);
    do_reset();
    while (t < 50) step(1'b0, 24'h0);
    for (int j = 0; j < 5; j++) begin
      step(1'b1, pix[j]);
      n_checks++;
      if (obs_vec() !== exp_vec()) $display("FAIL overflow_fill j=%0d got %h want %h", j, obs_vec(), exp_vec());
      else n_pass++;
      if (j == 2) begin
        n_checks++;
        if (PIX_REQ !== 1'b0) $display("FAIL overflow_req_drop got %b want 0", PIX_REQ);
        else n_pass++;
      end
    end
    n_checks++;
    if (OVERFLOW !== 1'b1) $display("FAIL overflow_flag got %b want 1", OVERFLOW);
    else n_pass++;
    while (t < 106) begin
      step(1'b0, 24'h0);
      n_checks++;
      if (obs_vec() !== exp_vec()) $display("FAIL overflow_drain t=%0d got %h want %h", t, obs_vec(), exp_vec());
      else n_pass++;
      if (t >= 98 && t <= 104 && (t % 2) == 0) begin
        n_checks++;
        if (VGA_RGB !== pix[(t - 98) / 2]) $display("FAIL overflow_order t=%0d got %h want %h", t, VGA_RGB, pix[(t - 98) / 2]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_push_pop();
    int next_pix;
    logic val;
    do_reset();
    next_pix = 24'h100;
    while (t < 140) begin
      if (t < 46 || t >= 100) val = (q.size() <= DEPTH - 2);
      else val = (t == 99);
      step(val, 24'(next_pix));
      if (val) next_pix++;
      n_checks++;
      if (obs_vec() !== exp_vec()) $display("FAIL push_pop t=%0d got %h want %h", t, obs_vec(), exp_vec());
      else n_pass++;
      if (t == 100) begin
        n_checks++;
        if (PIX_REQ !== 1'b1 || OVERFLOW !== 1'b0 || UNDERFLOW !== 1'b0)
          $display("FAIL push_pop_same got req=%b of=%b uf=%b want 1 0 0", PIX_REQ, OVERFLOW, UNDERFLOW);
        else n_pass++;
      end
    end
  endtask

  task automatic test_reset_mid();
    int edges;
    do_reset();
    while (t < 22) step(1'b0, 24'h0);
    n_checks++;
    if (DE !== 1'b1 || UNDERFLOW !== 1'b1) $display("FAIL mid_pre got de=%b uf=%b want 1 1", DE, UNDERFLOW);
    else n_pass++;
    RESET = 1'b1;
    @(posedge CLK); #1;
    n_checks++;
    if (obs_vec() !== RESET_VEC) $display("FAIL mid_reset got %h want %h", obs_vec(), RESET_VEC);
    else n_pass++;
    RESET = 1'b0;
    model_clear();
    #1;
    n_checks++;
    if (PIX_REQ !== 1'b1) $display("FAIL mid_req got %b want 1", PIX_REQ);
    else n_pass++;
    edges = 0;
    while (FRAME_START !== 1'b1 && edges < 10) begin
      step(1'b0, 24'h0);
      edges++;
    end
    n_checks++;
    if (edges != 2) $display("FAIL mid_frame_start got %0d edges want 2", edges);
    else n_pass++;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 2) != 0, 24'($urandom));
      n_checks++;
      if (obs_vec() !== exp_vec()) $display("FAIL random t=%0d got %h want %h", t, obs_vec(), exp_vec());
      else n_pass++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    model_clear();
    test_reset();
    test_free_run();
    test_stream();
    test_underflow();
    test_overflow();
    test_push_pop();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
